// File: rtl/cat_rec_pkg.sv
// Shared types and constants for the cat recognition MAC sequencer.
// Holds the FSM state encoding, the lane count and the accumulator saturation limits.
package cat_rec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_MAC    = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned LANES = 4;

  // Signed range limits for an accumulator of width w (w <= 64).
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam int unsigned             ACC_W_DEF   = 32;
  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX_DEF = ACC_W_DEF'(sat_max(ACC_W_DEF));
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN_DEF = ACC_W_DEF'(sat_min(ACC_W_DEF));

endpackage

// File: rtl/cat_dot4.sv
// Combinational dot product of unsigned pixels and signed weights across all lanes.
// Each product is formed at full precision and summed without loss.
module cat_dot4
  import cat_rec_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned WORD_W     = LANES * DATA_WIDTH,
  localparam int unsigned PROD_W     = 2 * DATA_WIDTH + 1,
  localparam int unsigned DOT_W      = PROD_W + 2
) (
  input  logic              [WORD_W-1:0] pix,
  input  logic              [WORD_W-1:0] wgt,
  output logic signed       [DOT_W-1:0]  dot
);

  logic signed [DATA_WIDTH:0]   pix_ext;
  logic signed [DATA_WIDTH-1:0] wgt_lane;
  logic signed [PROD_W-1:0]     prod;

  always_comb begin
    dot      = '0;
    pix_ext  = '0;
    wgt_lane = '0;
    prod     = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      pix_ext  = {1'b0, pix[l*DATA_WIDTH +: DATA_WIDTH]};
      wgt_lane = wgt[l*DATA_WIDTH +: DATA_WIDTH];
      prod     = pix_ext * wgt_lane;
      dot      = dot + DOT_W'(prod);
    end
  end

endmodule

// File: rtl/cat_mac_sequencer.sv
// Walks the image/weight banks word by word, accumulates a saturating dot product,
// then adds the bias and flags a cat when the total is non-negative.
module cat_mac_sequencer
  import cat_rec_pkg::*;
#(
  parameter  int unsigned AMBA_WORD  = 32,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned NUM_WORDS  = 4,
  parameter  int unsigned ACC_WIDTH  = 32,
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        start_i,
  output logic        [IDX_W-1:0]     img_idx_o,
  input  logic        [AMBA_WORD-1:0] img_data_i,
  output logic        [IDX_W-1:0]     w_idx_o,
  input  logic        [AMBA_WORD-1:0] w_data_i,
  input  logic signed [ACC_WIDTH-1:0] bias_i,
  output logic                        busy_o,
  output logic                        iter_done_o,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic                        result_o,
  output logic                        done_o
);

  localparam int unsigned DOT_W = 2 * DATA_WIDTH + 3;
  localparam int unsigned SUM_W = ((ACC_WIDTH > DOT_W) ? ACC_WIDTH : DOT_W) + 1;
  localparam int unsigned DEC_W = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
  localparam logic        [IDX_W-1:0]     LAST_K  = IDX_W'(NUM_WORDS - 1);

  state_t                      state_q, state_nxt;
  logic        [IDX_W-1:0]     k_q, k_nxt;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic                        result_nxt;
  logic                        iter_nxt;
  logic        [IDX_W-1:0]     idx_nxt;
  logic signed [DOT_W-1:0]     dot;
  logic signed [SUM_W-1:0]     sum_wide;
  logic signed [DEC_W-1:0]     dec_sum;

  cat_dot4 #(.DATA_WIDTH(DATA_WIDTH)) u_dot4 (
    .pix (img_data_i),
    .wgt (w_data_i),
    .dot (dot)
  );

  // Wide enough that neither the accumulator nor the dot product can overflow before clamping.
  assign sum_wide = SUM_W'(acc_o) + SUM_W'(dot);
  assign dec_sum  = DEC_W'(acc_o) + DEC_W'(bias_i);
  assign w_idx_o  = img_idx_o;

  always_comb begin
    state_nxt  = state_q;
    k_nxt      = k_q;
    acc_nxt    = acc_o;
    result_nxt = result_o;
    iter_nxt   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_nxt   = '0;
          k_nxt     = '0;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_MAC;
      ST_MAC: begin
        iter_nxt = 1'b1;
        if (sum_wide > SUM_W'(ACC_MAX))      acc_nxt = ACC_MAX;
        else if (sum_wide < SUM_W'(ACC_MIN)) acc_nxt = ACC_MIN;
        else                                 acc_nxt = ACC_WIDTH'(sum_wide);
        if (k_q == LAST_K) begin
          state_nxt = ST_DECIDE;
        end else begin
          k_nxt     = k_q + IDX_W'(1);
          state_nxt = ST_FETCH;
        end
      end
      ST_DECIDE: begin
        result_nxt = ~dec_sum[DEC_W-1];
        state_nxt  = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    idx_nxt = (state_nxt == ST_FETCH || state_nxt == ST_MAC) ? k_nxt : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      acc_o       <= '0;
      result_o    <= 1'b0;
      iter_done_o <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      img_idx_o   <= '0;
    end else begin
      state_q     <= state_nxt;
      k_q         <= k_nxt;
      acc_o       <= acc_nxt;
      result_o    <= result_nxt;
      iter_done_o <= iter_nxt;
      done_o      <= (state_nxt == ST_DONE);
      busy_o      <= (state_nxt != ST_IDLE);
      img_idx_o   <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_cat_mac_sequencer.sv
// Randomized bench for cat_mac_sequencer: default 32-bit and a 16-bit saturating instance
// run side by side against an arithmetic reference model.
module tb_cat_mac_sequencer;

  localparam int NW = 4;

  logic               PCLK;
  logic               PRESETn;
  logic               start;
  logic signed [31:0] bias0;
  logic signed [15:0] bias1;
  logic [31:0]        img_mem [NW];
  logic [31:0]        w_mem   [NW];

  logic [1:0]         img_idx0, w_idx0, img_idx1, w_idx1;
  logic [31:0]        img_q0, w_q0, img_q1, w_q1;
  logic               busy0, iter0, result0, done0;
  logic               busy1, iter1, result1, done1;
  logic signed [31:0] acc0;
  logic signed [15:0] acc1;

  int n_checks = 0;
  int n_pass   = 0;

  cat_mac_sequencer u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .start_i(start),
    .img_idx_o(img_idx0), .img_data_i(img_q0), .w_idx_o(w_idx0), .w_data_i(w_q0),
    .bias_i(bias0), .busy_o(busy0), .iter_done_o(iter0), .acc_o(acc0),
    .result_o(result0), .done_o(done0)
  );

  cat_mac_sequencer #(.ACC_WIDTH(16)) u_dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .start_i(start),
    .img_idx_o(img_idx1), .img_data_i(img_q1), .w_idx_o(w_idx1), .w_data_i(w_q1),
    .bias_i(bias1), .busy_o(busy1), .iter_done_o(iter1), .acc_o(acc1),
    .result_o(result1), .done_o(done1)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Synchronous bank read: data follows the index by one cycle.
  always @(posedge PCLK) begin
    img_q0 <= img_mem[img_idx0];
    w_q0   <= w_mem[w_idx0];
    img_q1 <= img_mem[img_idx1];
    w_q1   <= w_mem[w_idx1];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // mode 0 random, 1 zero pixels, 2 pixels FF / weights 80, 3 pixels FF / weights 7F
  task automatic fill(input int mode);
    for (int i = 0; i < NW; i++) begin
      img_mem[i] = (mode == 1) ? 32'h0 : (mode >= 2) ? 32'hFFFF_FFFF : $urandom();
      w_mem[i]   = (mode == 2) ? 32'h8080_8080 : (mode == 3) ? 32'h7F7F_7F7F : $urandom();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy0"}, busy0, 0);     chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_done0"}, done0, 0);     chk({tag, "_done1"}, done1, 0);
    chk({tag, "_iter0"}, iter0, 0);     chk({tag, "_iter1"}, iter1, 0);
    chk({tag, "_acc0"}, acc0, 0);       chk({tag, "_acc1"}, acc1, 0);
    chk({tag, "_res0"}, result0, 0);    chk({tag, "_res1"}, result1, 0);
    chk({tag, "_idx0"}, img_idx0, 0);   chk({tag, "_widx1"}, w_idx1, 0);
  endtask

  // One operation (or, with b2b, the spurious-start / back-to-back scenario).
  task automatic run_op(input int bias, input bit b2b);
    longint p0 [NW];
    longint p1 [NW];
    longint m0, m1, d;
    int pv, wv, rel, n_done, lim, exp_idx;
    bit r0, r1, exp_iter;
    logic signed [15:0] b16;
    m0 = 0; m1 = 0;
    for (int i = 0; i < NW; i++) begin
      d = 0;
      for (int l = 0; l < 4; l++) begin
        pv = int'(img_mem[i][8*l +: 8]);
        wv = int'($signed(w_mem[i][8*l +: 8]));
        d += longint'(pv * wv);
      end
      m0 = clamp(m0 + d, -(64'sd1 <<< 31), (64'sd1 <<< 31) - 1);
      m1 = clamp(m1 + d, -32768, 32767);
      p0[i] = m0; p1[i] = m1;
    end
    b16 = 16'(bias);
    r0 = (m0 + longint'(bias)) >= 0;
    r1 = (m1 + longint'(b16)) >= 0;
    n_done = 0;
    @(negedge PCLK);
    start = 1'b1; bias0 = bias; bias1 = b16;
    @(posedge PCLK);
    lim = b2b ? 24 : 13;
    for (int c = 1; c <= lim; c++) begin
      @(negedge PCLK);
      rel = (b2b && c > 11) ? c - 11 : c;
      exp_idx  = (rel <= 8) ? (rel - 1) / 2 : 0;
      exp_iter = (rel >= 3 && rel <= 9 && (rel % 2) == 1);
      chk("img_idx0", img_idx0, exp_idx);
      chk("w_idx0", w_idx0, exp_idx);
      chk("w_idx1", w_idx1, exp_idx);
      chk("busy0", busy0, (rel <= 10) ? 1 : 0);
      chk("busy1", busy1, (rel <= 10) ? 1 : 0);
      chk("iter0", iter0, exp_iter);
      chk("iter1", iter1, exp_iter);
      chk("done0", done0, (rel == 10) ? 1 : 0);
      chk("done1", done1, (rel == 10) ? 1 : 0);
      if (exp_iter) begin
        chk("acc_part0", acc0, p0[(rel - 3) / 2]);
        chk("acc_part1", acc1, p1[(rel - 3) / 2]);
      end
      if (rel >= 10) begin
        chk("acc_final0", acc0, m0);
        chk("acc_final1", acc1, m1);
        chk("result0", result0, r0);
        chk("result1", result1, r1);
      end
      if (done0) n_done++;
      start = b2b && (c == 3 || c == 10 || c == 11);
    end
    start = 1'b0;
    chk("done_count", n_done, b2b ? 2 : 1);
  endtask

  initial begin
    PRESETn = 1'b0; start = 1'b0; bias0 = '0; bias1 = '0;
    fill(0);
    repeat (3) @(negedge PCLK);
    chk_all_zero("reset");
    PRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      chk("idle_done", done0, 0);
      chk("idle_busy", busy0, 0);
    end

    fill(1); run_op(0, 1'b0);
    chk("zero_pix_acc", acc0, 0);
    chk("zero_pix_res", result0, 1);

    fill(2); run_op(522239, 1'b0);
    chk("ff80_acc", acc0, -522240);
    chk("ff80_res_lo", result0, 0);
    run_op(522240, 1'b0);
    chk("ff80_res_hi", result0, 1);

    fill(3); run_op(0, 1'b0);
    chk("sat16_acc", acc1, 32767);
    chk("sat16_res", result1, 1);

    for (int t = 0; t < 8; t++) begin
      fill(0);
      run_op(int'($urandom_range(2000000, 0)) - 1000000, 1'b0);
    end

    fill(0); run_op(int'($urandom_range(400, 0)) - 200, 1'b1);

    // Reset asserted mid-operation must clear everything immediately.
    fill(3);
    @(negedge PCLK);
    start = 1'b1; bias0 = 32'sd5; bias1 = 16'sd5;
    @(posedge PCLK);
    for (int c = 1; c <= 5; c++) begin
      @(negedge PCLK);
      start = 1'b0;
    end
    chk("pre_rst_busy", busy0, 1);
    PRESETn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge PCLK);
      chk("post_rst_done0", done0, 0);
      chk("post_rst_done1", done1, 0);
    end
    fill(0); run_op(int'($urandom_range(2000, 0)) - 1000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
